// File: rtl/instr_encoder_if.sv
// Beat/memory bus between the program loader, the instruction encoder and the
// instruction-memory write port.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [4:0]            in_mnem;
  logic [4:0]            in_rs;
  logic [4:0]            in_rt;
  logic [4:0]            in_rd;
  logic [15:0]           in_imm;
  logic [25:0]           in_target;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;

  modport master (
    output in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs symbolic instruction beats into 32-bit
// CPU words and writes them to instruction memory at sequential addresses.
module instr_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_encoder_if.slave      bus,
  output logic [ADDR_WIDTH:0] word_count,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic                err
);
  typedef enum logic [1:0] {FMT_I, FMT_J, FMT_R, FMT_JR} fmt_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic       legal;
    fmt_t       fmt;
    logic [5:0] op;
    logic [5:0] func;
  } mnem_info_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);

  // Field layout, opcode and function code for every mnemonic the decoder knows.
  function automatic mnem_info_t mnem_info(input int code);
    mnem_info_t info;
    info.legal = 1'b1;
    info.fmt   = FMT_R;
    info.op    = 6'h00;
    info.func  = 6'h00;
    case (code)
      0:  begin info.fmt = FMT_I;  info.op = 6'h23; end
      1:  begin info.fmt = FMT_I;  info.op = 6'h2b; end
      2:  begin info.fmt = FMT_J;  info.op = 6'h02; end
      3:  begin info.fmt = FMT_J;  info.op = 6'h03; end
      4:  begin info.fmt = FMT_I;  info.op = 6'h05; end
      5:  begin info.fmt = FMT_I;  info.op = 6'h08; end
      6:  info.func = 6'h0e;
      7:  info.func = 6'h20;
      8:  info.func = 6'h22;
      9:  info.func = 6'h2a;
      10: begin info.fmt = FMT_JR; info.func = 6'h08; end
      11: begin info.op = 6'h11;   info.func = 6'h00; end
      12: begin info.op = 6'h11;   info.func = 6'h02; end
      13: begin info.op = 6'h11;   info.func = 6'h03; end
      14: begin info.op = 6'h11;   info.func = 6'h04; end
      15: begin info.op = 6'h11;   info.func = 6'h05; end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

  mnem_info_t rom [32];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rom
      assign rom[gi] = mnem_info(gi);
    end
  endgenerate

  mnem_info_t  info;
  logic [31:0] enc_word;

  always_comb begin
    info     = rom[bus.in_mnem];
    enc_word = '0;
    case (info.fmt)
      FMT_I:   enc_word = {info.op, bus.in_rs, bus.in_rt, bus.in_imm};
      FMT_J:   enc_word = {info.op, bus.in_target};
      FMT_JR:  enc_word = {info.op, bus.in_rs, 15'd0, info.func};
      default: enc_word = {info.op, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, info.func};
    endcase
  end

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   word_count_reg;
  logic                  in_ready_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [31:0]           mem_data_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  full_reg;
  logic                  err_reg;

  logic accept;
  logic at_last;
  logic terminate;

  assign accept    = (state_reg == RUN) && bus.in_valid;
  assign at_last   = (addr_reg == LAST_ADDR);
  // A legal write into the final word ends the load even without in_last.
  assign terminate = bus.in_last || (info.legal && at_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= FIRST_ADDR;
      word_count_reg <= '0;
      in_ready_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      full_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      if (start) begin
        // start wins over any beat presented in the same cycle
        state_reg      <= RUN;
        addr_reg       <= FIRST_ADDR;
        word_count_reg <= '0;
        in_ready_reg   <= 1'b1;
        busy_reg       <= 1'b1;
        done_reg       <= 1'b0;
        full_reg       <= 1'b0;
        err_reg        <= 1'b0;
      end else if (accept) begin
        if (info.legal) begin
          mem_we_reg     <= 1'b1;
          mem_addr_reg   <= addr_reg;
          mem_data_reg   <= enc_word;
          word_count_reg <= word_count_reg + COUNT_ONE;
          if (at_last) begin
            full_reg <= 1'b1;
          end else begin
            addr_reg <= addr_reg + ADDR_ONE;
          end
        end else begin
          err_reg <= 1'b1;
        end
        if (terminate) begin
          state_reg    <= DONE;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.mem_we   = mem_we_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_data = mem_data_reg;
  assign word_count   = word_count_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign full         = full_reg;
  assign err          = err_reg;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench: a 1024-word and a 4-word encoder share one stimulus stream and
// are checked every cycle against a count-based model of the load rules.
module tb_instr_encoder;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [4:0]  in_mnem = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  instr_encoder_if #(.ADDR_WIDTH(10)) bus_b ();
  instr_encoder_if #(.ADDR_WIDTH(2))  bus_s ();

  logic [10:0] wc_b;
  logic [2:0]  wc_s;
  logic        busy_b, done_b, full_b, err_b;
  logic        busy_s, done_s, full_s, err_s;

  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_last   = in_last;
  assign bus_b.in_mnem   = in_mnem;
  assign bus_b.in_rs     = in_rs;
  assign bus_b.in_rt     = in_rt;
  assign bus_b.in_rd     = in_rd;
  assign bus_b.in_imm    = in_imm;
  assign bus_b.in_target = in_target;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_last   = in_last;
  assign bus_s.in_mnem   = in_mnem;
  assign bus_s.in_rs     = in_rs;
  assign bus_s.in_rt     = in_rt;
  assign bus_s.in_rd     = in_rd;
  assign bus_s.in_imm    = in_imm;
  assign bus_s.in_target = in_target;

  instr_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(bus_b),
    .word_count(wc_b), .busy(busy_b), .done(done_b), .full(full_b), .err(err_b)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .reset(reset), .start(start), .bus(bus_s),
    .word_count(wc_s), .busy(busy_s), .done(done_s), .full(full_s), .err(err_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Opcode/function tables indexed by mnemonic code.
  int op_of [16] = '{35, 43, 2, 3, 5, 8, 0, 0, 0, 0, 0, 17, 17, 17, 17, 17};
  int fn_of [16] = '{0, 0, 0, 0, 0, 0, 14, 32, 34, 42, 8, 0, 2, 3, 4, 5};

  function automatic bit tb_encode(input int mn, input int rs, input int rt, input int rd,
                                   input int imm, input int tgt, output logic [31:0] w);
    longint v;
    w = '0;
    if (mn > 15) return 1'b0;
    v = longint'(op_of[mn]) * 64'd67108864;
    if (mn == 2 || mn == 3)                      v += tgt;
    else if (mn < 2 || mn == 4 || mn == 5)       v += rs * 2097152 + rt * 65536 + imm;
    else if (mn == 10)                           v += rs * 2097152 + fn_of[mn];
    else                                         v += rs * 2097152 + rt * 65536 + rd * 2048 + fn_of[mn];
    w = v[31:0];
    return 1'b1;
  endfunction

  // Model: index 0 is the 1024-word unit, index 1 the 4-word unit.
  int          cap [2]     = '{1024, 4};
  int          base [2]    = '{0, 0};
  int          m_state [2] = '{S_IDLE, S_IDLE};
  int          m_count [2] = '{0, 0};
  bit          m_err [2]   = '{1'b0, 1'b0};
  bit          m_full [2]  = '{1'b0, 1'b0};
  bit          m_we [2]    = '{1'b0, 1'b0};
  int          m_addr [2]  = '{0, 0};
  logic [31:0] m_data [2]  = '{32'd0, 32'd0};
  logic [31:0] mw;
  bit          mlegal;

  always @(posedge clk) begin
    mlegal = tb_encode(int'(in_mnem), int'(in_rs), int'(in_rt), int'(in_rd),
                       int'(in_imm), int'(in_target), mw);
    for (int k = 0; k < 2; k++) begin
      m_we[k] <= 1'b0;
      if (reset) begin
        m_state[k] <= S_IDLE;
        m_count[k] <= 0;
        m_err[k]   <= 1'b0;
        m_full[k]  <= 1'b0;
        m_addr[k]  <= 0;
        m_data[k]  <= '0;
      end else if (start) begin
        m_state[k] <= S_RUN;
        m_count[k] <= 0;
        m_err[k]   <= 1'b0;
        m_full[k]  <= 1'b0;
      end else if (m_state[k] == S_RUN && in_valid) begin
        if (mlegal) begin
          m_we[k]    <= 1'b1;
          m_addr[k]  <= base[k] + m_count[k];
          m_data[k]  <= mw;
          m_count[k] <= m_count[k] + 1;
          if (m_count[k] + 1 == cap[k]) m_full[k] <= 1'b1;
        end else begin
          m_err[k] <= 1'b1;
        end
        if (in_last || (mlegal && m_count[k] + 1 == cap[k])) m_state[k] <= S_DONE;
      end
    end
  end

  int          log_addr_b [$];
  logic [31:0] log_data_b [$];
  int          log_addr_s [$];

  task automatic check_unit(input string u, input int k, input logic rdy, input logic we,
                            input logic [31:0] addr, input logic [31:0] data, input logic [31:0] wc,
                            input logic bsy, input logic dn, input logic fl, input logic er);
    check({u, " in_ready"}, 32'(rdy), 32'(m_state[k] == S_RUN));
    check({u, " mem_we"}, 32'(we), 32'(m_we[k]));
    check({u, " mem_addr"}, addr, m_addr[k]);
    check({u, " mem_data"}, data, m_data[k]);
    check({u, " word_count"}, wc, m_count[k]);
    check({u, " busy"}, 32'(bsy), 32'(m_state[k] == S_RUN));
    check({u, " done"}, 32'(dn), 32'(m_state[k] == S_DONE));
    check({u, " full"}, 32'(fl), 32'(m_full[k]));
    check({u, " err"}, 32'(er), 32'(m_err[k]));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_unit("big", 0, bus_b.in_ready, bus_b.mem_we, 32'(bus_b.mem_addr), bus_b.mem_data,
                 32'(wc_b), busy_b, done_b, full_b, err_b);
      check_unit("small", 1, bus_s.in_ready, bus_s.mem_we, 32'(bus_s.mem_addr), bus_s.mem_data,
                 32'(wc_s), busy_s, done_s, full_s, err_s);
      if (bus_b.mem_we === 1'b1) begin
        log_addr_b.push_back(int'(bus_b.mem_addr));
        log_data_b.push_back(bus_b.mem_data);
        $display("write big   addr=%0d data=%08h", bus_b.mem_addr, bus_b.mem_data);
      end
      if (bus_s.mem_we === 1'b1) begin
        log_addr_s.push_back(int'(bus_s.mem_addr));
        $display("write small addr=%0d data=%08h", bus_s.mem_addr, bus_s.mem_data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic beat(input int mn, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input bit last);
    in_valid  = 1'b1;
    in_mnem   = mn[4:0];
    in_rs     = rs[4:0];
    in_rt     = rt[4:0];
    in_rd     = rd[4:0];
    in_imm    = imm[15:0];
    in_target = tgt[25:0];
    in_last   = last;
    next_cycle();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic clear_logs();
    log_addr_b.delete();
    log_data_b.delete();
    log_addr_s.delete();
  endtask

  task automatic expect_write(input string name, input int idx, input int addr, input logic [31:0] data);
    check({name, " log addr"}, (idx < log_addr_b.size()) ? log_addr_b[idx] : -1, addr);
    check({name, " log data"}, (idx < log_data_b.size()) ? log_data_b[idx] : 32'hxxxxxxxx, data);
  endtask

  initial begin
    next_cycle();
    checking = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset mem_we", 32'(bus_b.mem_we), 0);
    check("reset word_count", 32'(wc_b), 0);
    check("reset in_ready", 32'(bus_b.in_ready), 0);
    reset = 1'b0;
    next_cycle();

    // ADD / LW / J program
    clear_logs();
    pulse_start();
    beat(7, 1, 2, 3, 0, 0, 1'b0);
    beat(0, 29, 8, 0, 4, 0, 1'b0);
    beat(2, 0, 0, 0, 0, 'h100, 1'b1);
    @(negedge clk);
    check("prog1 done", 32'(done_b), 1);
    check("prog1 word_count", 32'(wc_b), 3);
    check("prog1 full", 32'(full_b), 0);
    next_cycle();
    check("prog1 writes", log_addr_b.size(), 3);
    expect_write("prog1 add", 0, 0, 32'h00221820);
    expect_write("prog1 lw", 1, 1, 32'h8FA80004);
    expect_write("prog1 j", 2, 2, 32'h08000100);

    // FPU, JR (rt/rd must be zeroed), XORI
    clear_logs();
    pulse_start();
    beat(11, 2, 4, 6, 0, 0, 1'b0);
    beat(10, 31, 5, 5, 0, 0, 1'b0);
    beat(6, 1, 2, 3, 0, 0, 1'b1);
    next_cycle();
    expect_write("add.s", 0, 0, 32'h44443000);
    expect_write("jr", 1, 1, 32'h03E00008);
    expect_write("xori", 2, 2, 32'h0022180E);

    // Illegal mnemonic between two legal beats
    clear_logs();
    pulse_start();
    beat(7, 1, 2, 3, 0, 0, 1'b0);
    beat(20, 9, 9, 9, 9, 9, 1'b0);
    beat(8, 4, 5, 6, 0, 0, 1'b1);
    next_cycle();
    next_cycle();
    check("illegal writes", log_addr_b.size(), 2);
    expect_write("illegal first", 0, 0, 32'h00221820);
    expect_write("illegal second", 1, 1, 32'h00853022);
    check("illegal err sticky", 32'(err_b), 1);
    pulse_start();
    @(negedge clk);
    check("err cleared by start", 32'(err_b), 0);

    // Six beats without in_last: the 4-word unit fills up
    clear_logs();
    next_cycle();
    for (int i = 0; i < 6; i++) beat(5, i, i + 1, 0, i * 3, 0, 1'b0);
    @(negedge clk);
    check("small word_count", 32'(wc_s), 4);
    check("small full", 32'(full_s), 1);
    check("small done", 32'(done_s), 1);
    check("small in_ready", 32'(bus_s.in_ready), 0);
    check("big word_count", 32'(wc_b), 6);
    next_cycle();
    check("small writes", log_addr_s.size(), 4);
    for (int i = 0; i < 4; i++) check("small addr", (i < log_addr_s.size()) ? log_addr_s[i] : -1, i);

    // start together with a beat during RUN: beat dropped, load restarts
    clear_logs();
    start = 1'b1;
    beat(7, 1, 2, 3, 0, 0, 1'b0);
    start = 1'b0;
    beat(0, 29, 8, 0, 4, 0, 1'b0);
    beat(2, 0, 0, 0, 0, 'h100, 1'b1);
    next_cycle();
    check("restart writes", log_addr_b.size(), 2);
    expect_write("restart first", 0, 0, 32'h8FA80004);
    check("restart word_count", 32'(wc_b), 2);

    // Reset in the cycle right after an accept
    pulse_start();
    beat(7, 1, 2, 3, 0, 0, 1'b0);
    reset = 1'b1;
    next_cycle();
    check("abort mem_we", 32'(bus_b.mem_we), 0);
    check("abort mem_addr", 32'(bus_b.mem_addr), 0);
    check("abort mem_data", bus_b.mem_data, 0);
    check("abort word_count", 32'(wc_b), 0);
    check("abort busy", 32'(busy_b), 0);
    reset = 1'b0;
    next_cycle();
    next_cycle();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder and program loader for the single-cycle MIPS-subset CPU/FPU. It accepts one symbolic instruction per handshake beat (mnemonic code plus operand fields) and packs it into the 32-bit word the CPU's instruction decoder consumes. It writes each word into instruction memory at sequential addresses. It sits between the test/boot loader and the instruction-memory write port, and produces exactly the opcode/function encodings the decoder recognises.

## Interface
Parameters:
- ADDR_WIDTH, 10: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 0: first word address written after `start`.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse that begins or restarts a load.
- in_valid  input  1  instruction beat valid.
- in_ready  output  1  encoder can accept a beat.
- in_last  input  1  this beat is the final instruction of the program.
- in_mnem  input  5  mnemonic code (see Operation).
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate or branch offset.
- in_target  input  26  jump target.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  write word address.
- mem_data  output  32  encoded instruction word.
- word_count  output  ADDR_WIDTH+1  words written since `start`.
- busy  output  1  state is RUN.
- done  output  1  state is DONE.
- full  output  1  load ended because the last address was written.
- err  output  1  sticky: an illegal mnemonic was received.

## Operation
Mnemonic codes and encodings (op, rs, rt, rd, shamt=0, func):
- 0 LW: op 0x23, rs, rt, imm. 1 SW: op 0x2b, rs, rt, imm. 4 BNE: op 0x05, rs, rt, imm. 5 ADDI: op 0x08, rs, rt, imm.
- 2 J: op 0x02, target. 3 JAL: op 0x03, target.
- R-type, op 0x00 with rs, rt, rd: 6 XORI func 0x0e; 7 ADD 0x20; 8 SUB 0x22; 9 SLT 0x2a.
- 10 JR: op 0x00, rs, rt=rd=0, func 0x08.
- FPU, op 0x11 with rs, rt, rd: 11 ADD.S func 0x00; 12 MUL.S 0x02; 13 DIV.S 0x03; 14 SQRT.S 0x04; 15 MULI.S 0x05.
- Codes 16–31 are illegal. An illegal beat is accepted, consumed and not written. It sets `err`. `addr` and `word_count` are unchanged. If `in_last` is set on an illegal beat, the load still goes to DONE.

State machine:
- IDLE: `in_ready`=0. `start` → RUN.
- RUN: `in_ready`=1. A beat is accepted when `in_valid` and `in_ready` are both high. An accepted beat with `in_last`, or a legal beat written at address 2^ADDR_WIDTH−1, → DONE. A beat written at 2^ADDR_WIDTH−1 also sets `full`.
- DONE: `in_ready`=0. `start` → RUN.

On `start` in any state, including RUN:
- `addr` ← BASE_ADDR, `word_count` ← 0.
- `err` and `full` are cleared.
- Any beat presented in the same cycle is ignored; `start` has priority.

Internal `addr` advances by 1 per legal beat. It cannot wrap, because the load stops at the last address. When BASE_ADDR > 0, the capacity is 2^ADDR_WIDTH − BASE_ADDR words.

## Timing
- Reset values: state IDLE; `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `word_count`=0, `busy`=0, `done`=0, `full`=0, `err`=0.
- Latency: a beat accepted at edge N drives `mem_we`=1 with `mem_addr`/`mem_data` during cycle N+1 (output register). `word_count` updates at the same edge.
- Throughput: one beat per cycle in RUN; there is no back-pressure from memory.
- `mem_we` is high for exactly one cycle per legal beat and is 0 otherwise. `mem_addr`/`mem_data` hold their last values while `mem_we`=0.
- `in_ready` drops in the cycle after the terminating beat is accepted. `done` rises in that same cycle.
- When RUN is entered, `busy` rises one cycle after the `start` edge.
- Reset mid-load aborts immediately. The pending output-register write is dropped, and `mem_we`=0 in the cycle after the reset edge.

## Test plan
- Reset, then start, then stream ADD rs1 rt2 rd3; LW rs29 rt8 imm4; J target 0x100 (last) → writes 0x00221820 @0, 0x8FA80004 @1, 0x08000100 @2 on consecutive cycles; `done`=1, `word_count`=3, `full`=0.
- FPU and JR: ADD.S rs2 rt4 rd6 → 0x44443000; JR rs31 (with rt=rd=5 on the inputs) → 0x03E00008; XORI rs1 rt2 rd3 → 0x0022180E.
- Illegal mnemonic 20 between two legal beats → only 2 writes, at addresses 0 and 1; `err`=1 until the next `start`.
- ADDR_WIDTH=2, stream 6 beats without `in_last` → 4 writes at addresses 0–3, then `full`=1, `done`=1, `in_ready`=0; beats 5–6 are not accepted.
- `start` asserted during RUN together with a valid beat → that beat is dropped, the next write goes to BASE_ADDR, and `word_count` restarts at 0/1.
- Reset asserted in the cycle after an accept → no `mem_we`; all outputs take their reset values.
